// File: rtl/jogo_pkg.sv
// Shared definitions for the button game: FSM state codes, LFSR taps and seed,
// plus the "pattern has a winning group" helper used by the pattern generator.
package jogo_pkg;

    typedef enum logic [3:0] {
        INICIAL  = 4'd0,
        PREPARAR = 4'd1,
        ESPERA   = 4'd2,
        COMPARAR = 4'd3,
        REGISTRA = 4'd4,
        PROXIMA  = 4'd5,
        FIM      = 4'd15
    } estado_t;

    // x^8 + x^6 + x^5 + x^4 + 1 for a left-shifting Fibonacci register
    localparam logic [7:0] LFSR_TAPS      = 8'hB8;
    localparam logic [7:0] SEMENTE_PADRAO = 8'hA5;

    function automatic logic tem_grupo_zero(input logic [7:0] v);
        logic achou;
        achou = 1'b0;
        for (int g = 0; g < 4; g++) begin
            if (v[2*g +: 2] == 2'b00) achou = 1'b1;
        end
        return achou;
    endfunction

endpackage

// File: rtl/comparador_jog.sv
// Hit detector: a play hits when any pressed button sits on a 2'b00 group of A.
module comparador_jog (
    input  logic [7:0] A,
    input  logic [3:0] B,
    output logic       acerto
);

    always_comb begin
        acerto = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if ((A[2*i +: 2] == 2'b00) && B[i]) acerto = 1'b1;
        end
    end

endmodule

// File: rtl/gerador_padrao_lfsr.sv
// Board pattern source: 8-bit Fibonacci LFSR with seed load, advance enable and
// forcing of group rodada to 2'b00 when the raw value has no winning group.
module gerador_padrao_lfsr
    import jogo_pkg::*;
#(
    parameter logic [7:0] SEMENTE = SEMENTE_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       avanca,
    input  logic [1:0] rodada,
    output logic [7:0] padrao_prox
);

    logic [7:0] lfsr_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q <= SEMENTE;
        end else if (avanca) begin
            lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    always_comb begin
        padrao_prox = lfsr_q;
        if (!tem_grupo_zero(lfsr_q)) padrao_prox[{rodada, 1'b0} +: 2] = 2'b00;
    end

endmodule

// File: rtl/controle_rodada_jog.sv
// Round sequencer for the button game: shows a pattern, waits for a fresh press,
// scores hit/miss and ends after NUM_RODADAS rounds. TIMEOUT_JOGADA_EN adds the play timer.
module controle_rodada_jog
    import jogo_pkg::*;
#(
    parameter int          NUM_RODADAS = 8,
    parameter int          TIMEOUT     = 1000,
    parameter logic [7:0]  SEMENTE     = SEMENTE_PADRAO,
    localparam int         W           = $clog2(NUM_RODADAS + 1)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         iniciar,
    input  logic [3:0]   jogada,
    output logic [7:0]   padrao,
    output logic [W-1:0] rodada,
    output logic [W-1:0] acertos,
    output logic [W-1:0] erros,
    output logic         esperando,
    output logic         acerto_rodada,
    output logic         erro_rodada,
    output logic         timeout,
    output logic         pronto,
    output logic [3:0]   db_estado
);

    if (NUM_RODADAS < 1 || NUM_RODADAS > 255 || SEMENTE == 8'h00 || TIMEOUT < 1) begin : g_parametro_invalido
        $error("controle_rodada_jog: invalid parameter set");
    end

    estado_t      estado_q;
    logic [7:0]   padrao_q;
    logic [W-1:0] rodada_q, acertos_q, erros_q;
    logic [3:0]   jogada_ant_q, jogada_reg_q;
    logic         acerto_q, erro_q;
    logic         aceita, acerto_cmp, avanca;
    logic [1:0]   grupo_alvo;
    logic [7:0]   padrao_prox;

    // A play counts only on a 0000 -> nonzero edge, so held buttons never re-trigger.
    assign aceita     = (estado_q == ESPERA) && (jogada_ant_q == 4'b0000) && (jogada != 4'b0000);
    assign avanca     = (estado_q == PREPARAR);
    assign grupo_alvo = (estado_q == PROXIMA) ? 2'(rodada_q + 1'b1) : 2'b00;

`ifdef TIMEOUT_JOGADA_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0] timer_q;
    logic          expira;
    // NOTE: combinational so the pulse lands in the last espera cycle, not one after.
    assign expira  = (estado_q == ESPERA) && (timer_q == TW'(TIMEOUT - 1)) && !aceita;
    assign timeout = expira;
`else
    assign timeout = 1'b0;
`endif

    comparador_jog u_comparador (
        .A      (padrao_q),
        .B      (jogada_reg_q),
        .acerto (acerto_cmp)
    );

    gerador_padrao_lfsr #(.SEMENTE(SEMENTE)) u_gerador (
        .clock       (clock),
        .reset       (reset),
        .avanca      (avanca),
        .rodada      (grupo_alvo),
        .padrao_prox (padrao_prox)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q     <= INICIAL;
            padrao_q     <= '0;
            rodada_q     <= '0;
            acertos_q    <= '0;
            erros_q      <= '0;
            jogada_ant_q <= '0;
            jogada_reg_q <= '0;
            acerto_q     <= 1'b0;
            erro_q       <= 1'b0;
`ifdef TIMEOUT_JOGADA_EN
            timer_q      <= '0;
`endif
        end else begin
            jogada_ant_q <= jogada;
            acerto_q     <= 1'b0;
            erro_q       <= 1'b0;
            case (estado_q)
                INICIAL, FIM: begin
                    if (iniciar) begin
                        acertos_q <= '0;
                        erros_q   <= '0;
                        rodada_q  <= '0;
                        padrao_q  <= padrao_prox;
                        estado_q  <= PREPARAR;
                    end
                end
                PREPARAR: begin
`ifdef TIMEOUT_JOGADA_EN
                    timer_q  <= '0;
`endif
                    estado_q <= ESPERA;
                end
                ESPERA: begin
                    if (aceita) begin
                        jogada_reg_q <= jogada;
                        estado_q     <= COMPARAR;
                    end
`ifdef TIMEOUT_JOGADA_EN
                    else if (expira) begin
                        erro_q   <= 1'b1;
                        erros_q  <= erros_q + 1'b1;
                        estado_q <= REGISTRA;
                    end else begin
                        timer_q  <= timer_q + 1'b1;
                    end
`endif
                end
                COMPARAR: begin
                    // Score is committed here so pulse and counter appear together in registra.
                    if (acerto_cmp) begin
                        acerto_q  <= 1'b1;
                        acertos_q <= acertos_q + 1'b1;
                    end else begin
                        erro_q    <= 1'b1;
                        erros_q   <= erros_q + 1'b1;
                    end
                    estado_q <= REGISTRA;
                end
                REGISTRA: estado_q <= PROXIMA;
                PROXIMA: begin
                    if (rodada_q == W'(NUM_RODADAS - 1)) begin
                        estado_q <= FIM;
                    end else begin
                        rodada_q <= rodada_q + 1'b1;
                        padrao_q <= padrao_prox;
                        estado_q <= PREPARAR;
                    end
                end
                default: estado_q <= INICIAL;
            endcase
        end
    end

    assign padrao        = padrao_q;
    assign rodada        = rodada_q;
    assign acertos       = acertos_q;
    assign erros         = erros_q;
    assign esperando     = (estado_q == ESPERA);
    assign acerto_rodada = acerto_q;
    assign erro_rodada   = erro_q;
    assign pronto        = (estado_q == FIM);
    assign db_estado     = estado_q;

endmodule

// File: doc/controle_rodada_jog.md
Name: controle_rodada_jog

Overview:
- Round sequencer for the button game.
- Generates the 8-bit board pattern (four 2-bit groups), waits for the player's 4-bit press, and decides hit/miss with the existing comparador_jog.
- Keeps hit, miss and round counters; ends the game after NUM_RODADAS rounds.
- Sits between the button debouncers and the display/score logic.

Parameters:
- NUM_RODADAS, 8: rounds per game, range 1..255.
- TIMEOUT, 1000: clock cycles allowed per play in the espera state.
- SEMENTE, 8'hA5: LFSR reset value; must be nonzero.
- W, $clog2(NUM_RODADAS+1): counter width (derived localparam).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- iniciar  in  1  start/restart game (level, sampled).
- jogada  in  4  debounced buttons; bit i maps to pattern group i.
- padrao  out  8  current board pattern; group i = padrao[2i+1:2i].
- rodada  out  W  index of the current round, starting at 0.
- acertos  out  W  hit count.
- erros  out  W  miss count, timeouts included.
- esperando  out  1  high in the espera state.
- acerto_rodada  out  1  one-cycle pulse on a hit.
- erro_rodada  out  1  one-cycle pulse on a miss or timeout.
- timeout  out  1  one-cycle pulse when the play window expires.
- pronto  out  1  high in the fim state.
- db_estado  out  4  state code, for debug.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, on port reset; clock port is clock.
- Reset values: all outputs 0; state inicial; LFSR = SEMENTE; jogada_ant = 0.
- Hit rule: acerto = OR over i of (padrao[2i+1:2i]==2'b00 AND jogada_reg[i]). Computed by an instantiated comparador_jog with A = padrao and B = jogada_reg.
- Play acceptance: a play is accepted only in espera, on a transition of jogada from 4'b0000 (previous cycle) to nonzero. jogada_ant is tracked in every state.
  - A button held across a round boundary is not accepted until it is released.
  - Multi-bit presses are accepted; hit if any pressed bit hits.
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1. Advances once per preparar cycle, after its value is sampled.
- Pattern forcing: if the sampled LFSR value has no 2'b00 group, group rodada[1:0] is cleared to 00. Every round therefore has at least one winning button.
- States (db_estado code):
  - inicial (0): iniciar=1 clears counters and goes to preparar.
  - preparar (1): padrao <= forced LFSR value; timer <= 0; go to espera.
  - espera (2): timer increments. On an accepted play: jogada_reg <= jogada, go to comparar. Else if timer==TIMEOUT-1: pulse timeout, go to registra as a miss.
  - comparar (3): latch the comparator result; go to registra.
  - registra (4): pulse acerto_rodada or erro_rodada; increment acertos or erros; go to proxima.
  - proxima (5): if rodada==NUM_RODADAS-1 go to fim; else rodada+1, go to preparar.
  - fim (15): pronto=1; counters hold. iniciar=1 clears counters and rodada, goes to preparar. The LFSR is not reseeded.
- Latency: accepted play in cycle N → comparar N+1 → pulse and counter update visible N+2 → next padrao visible N+4.
- Simultaneous events:
  - Accepted play and timeout expiry in the same cycle: the play wins.
  - iniciar in any state other than inicial or fim: ignored.
- Reset mid-operation: immediate return to reset values next edge, including LFSR and pattern.
- Counter width: counters saturate-free; they cannot exceed NUM_RODADAS.

Optional Feature:
- Macro TIMEOUT_JOGADA_EN.
- Defined: timer, TIMEOUT expiry path and the timeout pulse exist as described.
- Undefined: no timer; espera waits indefinitely; the timeout output is tied 0; the TIMEOUT parameter is unused.

Decomposition:
- Shared package jogo_pkg:
  - state encoding enum (4-bit codes above);
  - LFSR polynomial tap mask 8'hB8;
  - default SEMENTE.
- Natural sub-module: gerador_padrao_lfsr, containing the LFSR, advance enable, seed load and no-00 forcing. Inputs: rodada[1:0], avanca. Output: padrao_prox.
- comparador_jog is instantiated unchanged.

Test Plan:
- Reset, then iniciar=1 for 1 cycle → preparar then espera; padrao=8'hA4 (seed A5, group 0 forced); rodada=0; esperando=1.
- In round 0 (padrao A4), press jogada=4'b0001 → acerto_rodada pulse 2 cycles after acceptance; acertos=1; erros=0; rodada=1 two cycles later.
- In round 0 (padrao A4), press 4'b1000 (group 3 = 10) → erro_rodada pulse; erros=1.
- TIMEOUT=16, no press → timeout pulse on the 16th espera cycle, then erro_rodada 1 cycle later; erros increments. Without TIMEOUT_JOGADA_EN, esperando stays high for 100+ cycles.
- Hold 4'b0001 through registra into the next espera → no acceptance. Release to 0000 and press again → accepted.
- NUM_RODADAS=4, play 4 rounds → pronto=1, db_estado=15, counters hold. Then iniciar → acertos=erros=rodada=0. Separately, reset asserted mid-espera → all outputs 0 and padrao=0 next cycle; after iniciar, padrao=A4 again.
